// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared CBus request/response types plus the arbiter state encoding.
// Imported by the arbiter, its interface and any future scheduler.
package cbus_rr_arbiter_pkg;

    localparam int CBUS_ADDR_W = 32;
    localparam int CBUS_DATA_W = 32;
    localparam int CBUS_STRB_W = CBUS_DATA_W / 8;

    typedef enum logic [2:0] {
        CBUS_SIZE_B = 3'd0,
        CBUS_SIZE_H = 3'd1,
        CBUS_SIZE_W = 3'd2,
        CBUS_SIZE_D = 3'd3
    } cbus_size_t;

    // Burst length is encoded as beats minus one.
    typedef logic [3:0] cbus_len_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [CBUS_ADDR_W-1:0] addr;
        cbus_size_t             size;
        cbus_len_t              len;
        logic [CBUS_DATA_W-1:0] data;
        logic [CBUS_STRB_W-1:0] strb;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// Bundle of requester-side and memory-side CBus signals around the arbiter.
// slave = the arbiter itself, master = the surrounding requesters and memory.
interface cbus_rr_arbiter_if #(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_BITS   = $clog2(NUM_INPUTS)
) ();
    import cbus_rr_arbiter_pkg::*;

    cbus_req_t  [NUM_INPUTS-1:0] ireqs;
    cbus_resp_t [NUM_INPUTS-1:0] iresps;
    cbus_req_t                   oreq;
    cbus_resp_t                  oresp;
    logic       [IDX_BITS-1:0]   grant_idx;
    logic                        busy;

    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq,
        output grant_idx,
        output busy
    );

    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq,
        input  grant_idx,
        input  busy
    );

endinterface

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of valid_i at or after ptr_i, wrapping.
// Purely combinational so it can be reused and checked exhaustively on its own.
module cbus_rr_arbiter_rr_pick #(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_BITS   = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] valid_i,
    input  logic [IDX_BITS-1:0]   ptr_i,
    output logic                  found_o,
    output logic [IDX_BITS-1:0]   idx_o
);

    localparam logic [IDX_BITS:0] N_W = (IDX_BITS + 1)'(NUM_INPUTS);

    // One spare bit so ptr+k never overflows before the explicit wrap.
    logic [IDX_BITS:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = {1'b0, ptr_i} + (IDX_BITS + 1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found_o && valid_i[cand[IDX_BITS-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IDX_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin owner of the single CBus master port; grants whole transactions
// (all beats up to last) and leaves one idle cycle between owners.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_BITS   = $clog2(NUM_INPUTS)
) (
    input  logic             clk,
    input  logic             reset,
    cbus_rr_arbiter_if.slave bus
);

    arb_state_t            state_q;
    logic [IDX_BITS-1:0]   sel_q;
    logic [IDX_BITS-1:0]   rr_ptr_q;
    logic [IDX_BITS-1:0]   rr_ptr_d;
    logic [IDX_BITS-1:0]   grant_idx_q;
    logic                  busy_q;
    logic [NUM_INPUTS-1:0] req_valid;
    logic                  pick_found;
    logic [IDX_BITS-1:0]   pick_idx;
    logic                  xfer_done;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_valid
        assign req_valid[g] = bus.ireqs[g].valid;
    end

    cbus_rr_arbiter_rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_BITS   (IDX_BITS)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Explicit wrap keeps non-power-of-two port counts in range.
    function automatic logic [IDX_BITS-1:0] wrap_inc(input logic [IDX_BITS-1:0] i);
        return (i == IDX_BITS'(NUM_INPUTS - 1)) ? '0 : i + IDX_BITS'(1);
    endfunction

    assign rr_ptr_d  = wrap_inc(sel_q);
    assign xfer_done = (state_q == BUSY) && bus.oresp.ready && bus.oresp.last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q     <= BUSY;
                        sel_q       <= pick_idx;
                        grant_idx_q <= pick_idx;
                        busy_q      <= 1'b1;
                    end
                end
                BUSY: begin
                    if (xfer_done) begin
                        state_q     <= IDLE;
                        rr_ptr_q    <= rr_ptr_d;
                        grant_idx_q <= '0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The owner's request passes straight through so per-beat data/strobe track it.
    always_comb begin
        bus.oreq   = '0;
        bus.iresps = '0;
        if (state_q == BUSY) begin
            bus.oreq          = bus.ireqs[sel_q];
            bus.iresps[sel_q] = bus.oresp;
        end
    end

    assign bus.grant_idx = grant_idx_q;
    assign bus.busy      = busy_q;

    owner_holds_valid: assert property (
        @(posedge clk) disable iff (reset)
        (state_q == BUSY) |-> bus.ireqs[sel_q].valid
    );

endmodule
